// File: rtl/multicycle_ctrl_seq_if.sv
// Fetch/datapath handshake bundle for the multicycle control sequencer.
// The sequencer connects through the slave modport; its driver (fetch, memory, test) uses master.
interface multicycle_ctrl_seq_if #(
   parameter int unsigned CNT_W = 4
) ();
   logic             instr_valid;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             resume;
   logic [2:0]       stage;
   logic             fetch_req;
   logic             mem_req;
   logic             read_reg;
   logic             write_reg;
   logic             read_data;
   logic             write_data;
   logic             immediat;
   logic             control_function;
   logic             control_alu_data;
   logic             rtrn;
   logic             pop;
   logic             push;
   logic             add_pc;
   logic             brfl_control;
   logic [2:0]       branch;
   logic [5:0]       fnction;
   logic             write_pc;
   logic             illegal;
   logic             mem_err;
   logic [CNT_W-1:0] stage_cnt;

   modport master (
      output instr_valid, opcode, mem_ready, resume,
      input  stage, fetch_req, mem_req, read_reg, write_reg, read_data, write_data, immediat,
             control_function, control_alu_data, rtrn, pop, push, add_pc, brfl_control,
             branch, fnction, write_pc, illegal, mem_err, stage_cnt
   );

   modport slave (
      input  instr_valid, opcode, mem_ready, resume,
      output stage, fetch_req, mem_req, read_reg, write_reg, read_data, write_data, immediat,
             control_function, control_alu_data, rtrn, pop, push, add_pc, brfl_control,
             branch, fnction, write_pc, illegal, mem_err, stage_cnt
   );
endinterface

// File: rtl/multicycle_ctrl_seq.sv
// Multicycle stage sequencer for the MUSA core: IF/ID/EX/MEM/WB/HALT FSM with fetch handshake,
// MEM wait states with optional timeout, and registered decoded datapath controls.
module multicycle_ctrl_seq #(
   parameter bit          FAST_PATH    = 1'b1,
   parameter int unsigned MEM_WAIT_MAX = 0,
   parameter int unsigned CNT_W        = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_ctrl_seq_if.slave bus
);

   // StBoot reports stage IF but holds fetch_req low until the first edge after reset.
   typedef enum logic [2:0] {
      StIf   = 3'b000,
      StId   = 3'b001,
      StEx   = 3'b010,
      StMem  = 3'b011,
      StWb   = 3'b100,
      StHalt = 3'b101,
      StBoot = 3'b110
   } state_e;

   typedef struct packed {
      logic       read_reg;
      logic       write_reg;
      logic       read_data;
      logic       write_data;
      logic       immediat;
      logic       control_function;
      logic       control_alu_data;
      logic       rtrn;
      logic       pop;
      logic       push;
      logic       add_pc;
      logic       brfl_control;
      logic [2:0] branch;
      logic [5:0] fnction;
   } ctl_t;

   localparam int unsigned      WaitLastInt = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
   localparam logic [CNT_W-1:0] WaitLast    = WaitLastInt[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CntOne      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CntMax      = '1;

   state_e           state_q, state_d;
   ctl_t             ctl_q, ctl_d;
   logic             is_mem_q, is_mem_d;
   logic             is_halt_q, is_halt_d;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             mem_err;
   logic             timeout;

   ctl_t dec_ctl;
   logic dec_mem;
   logic dec_halt;
   logic dec_ill;

   always_comb begin
      dec_ctl  = '0;
      dec_mem  = 1'b0;
      dec_halt = 1'b0;
      dec_ill  = 1'b0;
      case (bus.opcode)
         6'b000000: begin
            dec_ctl.read_reg  = 1'b1;
            dec_ctl.write_reg = 1'b1;
         end
         6'b001000, 6'b001110, 6'b001100, 6'b001101: begin
            dec_ctl.read_reg         = 1'b1;
            dec_ctl.write_reg        = 1'b1;
            dec_ctl.immediat         = 1'b1;
            dec_ctl.control_function = 1'b1;
            // I-type opcode low bits select the matching R-type ALU function.
            case (bus.opcode[2:0])
               3'b000:  dec_ctl.fnction = 6'b100000;
               3'b110:  dec_ctl.fnction = 6'b100010;
               3'b100:  dec_ctl.fnction = 6'b100100;
               default: dec_ctl.fnction = 6'b100101;
            endcase
         end
         6'b100011, 6'b101011: begin
            dec_ctl.read_reg         = 1'b1;
            dec_ctl.write_reg        = ~bus.opcode[3];
            dec_ctl.write_data       = 1'b1;
            dec_ctl.immediat         = 1'b1;
            dec_ctl.control_function = 1'b1;
            dec_ctl.control_alu_data = 1'b1;
            dec_ctl.fnction          = 6'b100000;
            dec_mem                  = 1'b1;
         end
         6'b000011: begin
            dec_ctl.read_reg = 1'b1;
            dec_ctl.push     = 1'b1;
         end
         6'b000111: begin
            dec_ctl.read_reg = 1'b1;
            dec_ctl.pop      = 1'b1;
            dec_ctl.add_pc   = 1'b1;
         end
         6'b011000: begin
            dec_ctl.read_reg = 1'b1;
            dec_ctl.immediat = 1'b1;
            dec_ctl.branch   = 3'b010;
         end
         6'b001001: begin
            dec_ctl.immediat = 1'b1;
            dec_ctl.branch   = 3'b010;
         end
         6'b010001: begin
            dec_ctl.read_reg     = 1'b1;
            dec_ctl.branch       = 3'b100;
            dec_ctl.brfl_control = 1'b1;
         end
         6'b000010: begin
            dec_ctl.branch = 3'b101;
            dec_halt       = 1'b1;
         end
         6'b000001: ;
         default:   dec_ill = 1'b1;
      endcase
   end

   assign timeout = (MEM_WAIT_MAX != 0) && (wait_q == WaitLast);

   always_comb begin
      state_d   = state_q;
      ctl_d     = ctl_q;
      is_mem_d  = is_mem_q;
      is_halt_d = is_halt_q;
      ill_d     = ill_q;
      wait_d    = wait_q;
      cnt_d     = cnt_q;
      mem_err   = 1'b0;
      unique case (state_q)
         StBoot: state_d = StIf;
         StIf: begin
            if (bus.instr_valid) begin
               state_d   = StId;
               ctl_d     = dec_ctl;
               is_mem_d  = dec_mem;
               is_halt_d = dec_halt;
               ill_d     = dec_ill;
            end
         end
         StId: begin
            if (is_halt_q) begin
               state_d = StHalt;
               ctl_d   = '0;
            end else begin
               state_d = StEx;
            end
         end
         StEx: begin
            wait_d  = '0;
            state_d = (is_mem_q || !FAST_PATH) ? StMem : StWb;
         end
         StMem: begin
            // Non-memory instructions only pass through MEM for one cycle.
            if (!is_mem_q || bus.mem_ready) begin
               state_d = StWb;
            end else if (timeout) begin
               state_d = StWb;
               mem_err = 1'b1;
            end else begin
               wait_d = wait_q + CntOne;
            end
         end
         StWb: begin
            state_d = StIf;
            ctl_d   = '0;
         end
         StHalt: begin
            if (bus.resume) state_d = StIf;
         end
         default: state_d = StIf;
      endcase

      if (state_d == StIf && state_q != StIf) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StBoot;
         ctl_q     <= '0;
         is_mem_q  <= 1'b0;
         is_halt_q <= 1'b0;
         ill_q     <= 1'b0;
         cnt_q     <= '0;
         wait_q    <= '0;
      end else begin
         state_q   <= state_d;
         ctl_q     <= ctl_d;
         is_mem_q  <= is_mem_d;
         is_halt_q <= is_halt_d;
         ill_q     <= ill_d;
         cnt_q     <= cnt_d;
         wait_q    <= wait_d;
      end
   end

   assign bus.stage            = (state_q == StBoot) ? 3'b000 : state_q;
   assign bus.fetch_req        = (state_q == StIf);
   assign bus.mem_req          = (state_q == StMem);
   assign bus.write_pc         = (state_q == StWb);
   assign bus.illegal          = (state_q == StId) && ill_q;
   assign bus.mem_err          = mem_err;
   assign bus.stage_cnt        = cnt_q;
   assign bus.read_reg         = ctl_q.read_reg;
   assign bus.write_reg        = ctl_q.write_reg;
   assign bus.read_data        = ctl_q.read_data;
   assign bus.write_data       = ctl_q.write_data;
   assign bus.immediat         = ctl_q.immediat;
   assign bus.control_function = ctl_q.control_function;
   assign bus.control_alu_data = ctl_q.control_alu_data;
   assign bus.rtrn             = ctl_q.rtrn;
   assign bus.pop              = ctl_q.pop;
   assign bus.push             = ctl_q.push;
   assign bus.add_pc           = ctl_q.add_pc;
   assign bus.brfl_control     = ctl_q.brfl_control;
   assign bus.branch           = ctl_q.branch;
   assign bus.fnction          = ctl_q.fnction;

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Bench for multicycle_ctrl_seq: two builds (fast path, no timeout / full path, 5-cycle timeout)
// checked every cycle against an instruction-level model, plus hand-computed expectations.
module tb_multicycle_ctrl_seq;

   localparam int unsigned CNT_W  = 4;
   localparam int          WMAX_B = 5;
   localparam int          NEVER  = 1000;

   typedef struct packed {
      logic       read_reg;
      logic       write_reg;
      logic       read_data;
      logic       write_data;
      logic       immediat;
      logic       control_function;
      logic       control_alu_data;
      logic       rtrn;
      logic       pop;
      logic       push;
      logic       add_pc;
      logic       brfl_control;
      logic [2:0] branch;
      logic [5:0] fnction;
   } ctl_t;

   typedef struct packed {
      logic [2:0]       stage;
      logic             fetch_req;
      logic             mem_req;
      logic             write_pc;
      logic             illegal;
      logic             mem_err;
      logic [CNT_W-1:0] cnt;
      ctl_t             ctl;
   } obs_t;

   typedef struct {
      bit   primed;
      int   stage;
      ctl_t ctl;
      bit   is_mem;
      bit   is_halt;
      bit   ill;
      int   cnt;
      int   waited;
   } model_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       iv[2];
   logic [5:0] op[2];
   logic       mr[2];
   logic       rs[2];
   model_t     mdl[2];
   obs_t       obs_a, obs_b;
   int         vectors     = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_seq_if #(.CNT_W(CNT_W)) bus_a ();
   multicycle_ctrl_seq_if #(.CNT_W(CNT_W)) bus_b ();

   multicycle_ctrl_seq #(.FAST_PATH(1'b1), .MEM_WAIT_MAX(0), .CNT_W(CNT_W)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   multicycle_ctrl_seq #(.FAST_PATH(1'b0), .MEM_WAIT_MAX(WMAX_B), .CNT_W(CNT_W)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   assign bus_a.instr_valid = iv[0];
   assign bus_a.opcode      = op[0];
   assign bus_a.mem_ready   = mr[0];
   assign bus_a.resume      = rs[0];
   assign bus_b.instr_valid = iv[1];
   assign bus_b.opcode      = op[1];
   assign bus_b.mem_ready   = mr[1];
   assign bus_b.resume      = rs[1];

   always_comb begin
      obs_a           = '0;
      obs_a.stage     = bus_a.stage;
      obs_a.fetch_req = bus_a.fetch_req;
      obs_a.mem_req   = bus_a.mem_req;
      obs_a.write_pc  = bus_a.write_pc;
      obs_a.illegal   = bus_a.illegal;
      obs_a.mem_err   = bus_a.mem_err;
      obs_a.cnt       = bus_a.stage_cnt;
      obs_a.ctl       = {bus_a.read_reg, bus_a.write_reg, bus_a.read_data, bus_a.write_data,
                         bus_a.immediat, bus_a.control_function, bus_a.control_alu_data,
                         bus_a.rtrn, bus_a.pop, bus_a.push, bus_a.add_pc, bus_a.brfl_control,
                         bus_a.branch, bus_a.fnction};
   end

   always_comb begin
      obs_b           = '0;
      obs_b.stage     = bus_b.stage;
      obs_b.fetch_req = bus_b.fetch_req;
      obs_b.mem_req   = bus_b.mem_req;
      obs_b.write_pc  = bus_b.write_pc;
      obs_b.illegal   = bus_b.illegal;
      obs_b.mem_err   = bus_b.mem_err;
      obs_b.cnt       = bus_b.stage_cnt;
      obs_b.ctl       = {bus_b.read_reg, bus_b.write_reg, bus_b.read_data, bus_b.write_data,
                         bus_b.immediat, bus_b.control_function, bus_b.control_alu_data,
                         bus_b.rtrn, bus_b.pop, bus_b.push, bus_b.add_pc, bus_b.brfl_control,
                         bus_b.branch, bus_b.fnction};
   end

   function automatic obs_t obs_of(input int d);
      return (d != 0) ? obs_b : obs_a;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decode table straight from the opcode list.
   function automatic ctl_t ref_decode(input logic [5:0] o, output bit mem, output bit halt,
                                       output bit ill);
      ctl_t c;
      c = '0; mem = 1'b0; halt = 1'b0; ill = 1'b0;
      case (o)
         6'b000000: begin c.read_reg = 1; c.write_reg = 1; end
         6'b001000: begin c.read_reg = 1; c.write_reg = 1; c.immediat = 1;
                          c.control_function = 1; c.fnction = 6'b100000; end
         6'b001110: begin c.read_reg = 1; c.write_reg = 1; c.immediat = 1;
                          c.control_function = 1; c.fnction = 6'b100010; end
         6'b001100: begin c.read_reg = 1; c.write_reg = 1; c.immediat = 1;
                          c.control_function = 1; c.fnction = 6'b100100; end
         6'b001101: begin c.read_reg = 1; c.write_reg = 1; c.immediat = 1;
                          c.control_function = 1; c.fnction = 6'b100101; end
         6'b100011: begin c.read_reg = 1; c.write_reg = 1; c.write_data = 1; c.immediat = 1;
                          c.control_function = 1; c.control_alu_data = 1;
                          c.fnction = 6'b100000; mem = 1; end
         6'b101011: begin c.read_reg = 1; c.write_data = 1; c.immediat = 1;
                          c.control_function = 1; c.control_alu_data = 1;
                          c.fnction = 6'b100000; mem = 1; end
         6'b000011: begin c.read_reg = 1; c.push = 1; end
         6'b000111: begin c.read_reg = 1; c.pop = 1; c.add_pc = 1; end
         6'b011000: begin c.read_reg = 1; c.immediat = 1; c.branch = 3'b010; end
         6'b001001: begin c.immediat = 1; c.branch = 3'b010; end
         6'b010001: begin c.read_reg = 1; c.branch = 3'b100; c.brfl_control = 1; end
         6'b000010: begin c.branch = 3'b101; halt = 1; end
         6'b000001: ;
         default:   ill = 1;
      endcase
      return c;
   endfunction

   function automatic model_t model_reset();
      model_t m;
      m.primed = 0; m.stage = 0; m.ctl = '0; m.is_mem = 0; m.is_halt = 0; m.ill = 0;
      m.cnt = 0; m.waited = 0;
      return m;
   endfunction

   // Stage numbers follow the output encoding: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 5 HALT.
   function automatic model_t model_next(input model_t m, input bit fast, input int wmax,
                                         input logic v, input logic [5:0] o, input logic rdy,
                                         input logic res);
      model_t n;
      n = m;
      if (!m.primed) begin
         n.primed = 1; n.stage = 0; n.cnt = 0;
         return n;
      end
      case (m.stage)
         0: if (v) begin n.ctl = ref_decode(o, n.is_mem, n.is_halt, n.ill); n.stage = 1; end
         1: if (m.is_halt) begin n.stage = 5; n.ctl = '0; end else n.stage = 2;
         2: begin n.stage = (m.is_mem || !fast) ? 3 : 4; n.waited = 0; end
         3: begin
            n.waited = m.waited + 1;
            if (!m.is_mem || rdy || (wmax > 0 && n.waited == wmax)) n.stage = 4;
         end
         4: begin n.stage = 0; n.ctl = '0; end
         default: if (res) n.stage = 0;
      endcase
      if (n.stage == 0 && m.stage != 0) n.cnt = 0;
      else if (m.cnt < (1 << CNT_W) - 1) n.cnt = m.cnt + 1;
      return n;
   endfunction

   function automatic obs_t model_expect(input model_t m, input int wmax, input logic rdy);
      obs_t e;
      e           = '0;
      e.stage     = 3'(m.stage);
      e.fetch_req = m.primed && m.stage == 0;
      e.mem_req   = m.stage == 3;
      e.write_pc  = m.stage == 4;
      e.illegal   = m.stage == 1 && m.ill;
      e.mem_err   = m.stage == 3 && m.is_mem && !rdy && wmax > 0 && (m.waited + 1 == wmax);
      e.cnt       = CNT_W'(m.cnt);
      e.ctl       = m.ctl;
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl[0] <= model_reset();
         mdl[1] <= model_reset();
      end else begin
         mdl[0] <= model_next(mdl[0], 1'b1, 0, iv[0], op[0], mr[0], rs[0]);
         mdl[1] <= model_next(mdl[1], 1'b0, WMAX_B, iv[1], op[1], mr[1], rs[1]);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #1;
         check("model_dut_a", obs_a, model_expect(mdl[0], 0, mr[0]));
         check("model_dut_b", obs_b, model_expect(mdl[1], WMAX_B, mr[1]));
      end
   end

   task automatic wait_fetch(input int d);
      int g;
      g = 0;
      while (!obs_of(d).fetch_req && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) check("fetch_wait_timeout", 0, 1);
   endtask

   // One instruction from IF through WB; mem_ready is low for the first nlow MEM cycles.
   task automatic run(input int d, input logic [5:0] opc, input int nlow, output int len,
                      output int mem_cyc, output int err_cyc, output bit ill_seen,
                      output logic [5:0] fn_id);
      obs_t o;
      bit   done;
      wait_fetch(d);
      iv[d] = 1'b1; op[d] = opc; mr[d] = 1'b0;
      len = 1; mem_cyc = 0; err_cyc = 0; ill_seen = 0; fn_id = '0; done = 0;
      for (int g = 0; g < 64 && !done; g++) begin
         @(negedge clk);
         o = obs_of(d);
         len++;
         if (o.stage == 3'd1) begin
            iv[d] = 1'b0;
            fn_id = o.ctl.fnction;
            if (o.illegal) ill_seen = 1;
         end
         if (o.stage == 3'd3) begin
            mem_cyc++;
            mr[d] = (mem_cyc > nlow);
            #1;
            if (obs_of(d).mem_err) err_cyc = mem_cyc;
         end
         if (o.stage == 3'd4) done = 1;
      end
      iv[d] = 1'b0; mr[d] = 1'b0;
      if (!done) check("run_timeout", 0, 1);
   endtask

   task automatic run_halt(input int d, input int k, input int exp_cnt);
      obs_t o;
      int   h;
      bit   wpc;
      bit   done;
      wait_fetch(d);
      iv[d] = 1'b1; op[d] = 6'b000010;
      h = 0; wpc = 0; done = 0;
      for (int g = 0; g < 200 && !done; g++) begin
         @(negedge clk);
         o = obs_of(d);
         if (o.write_pc) wpc = 1;
         if (o.stage == 3'd1) iv[d] = 1'b0;
         if (o.stage == 3'b101) begin
            h++;
            if (h == k) begin
               check("halt_stage_cnt", o.cnt, exp_cnt);
               rs[d] = 1'b1;
            end
         end else if (h == k) begin
            check("halt_exit_stage", o.stage, 3'b000);
            check("halt_exit_ctl", o.ctl, 0);
            check("halt_no_write_pc", wpc, 0);
            rs[d] = 1'b0;
            done  = 1;
         end
      end
      rs[d] = 1'b0;
      if (!done) check("halt_timeout", 0, 1);
   endtask

   initial begin
      int         len, mc, ec;
      bit         il;
      logic [5:0] fn;
      obs_t       o;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; op[i] = '0; mr[i] = 1'b0; rs[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      check("reset_outputs_a", obs_a, 0);
      check("reset_outputs_b", obs_b, 0);
      rst_n = 1'b1;

      // Fast-path build, no MEM timeout.
      run(0, 6'b001000, 0, len, mc, ec, il, fn);
      check("addi_len", len, 4);
      check("addi_fnction", fn, 6'b100000);
      run(0, 6'b100011, 3, len, mc, ec, il, fn);
      check("lw_wait_len", len, 8);
      check("lw_wait_mem_cycles", mc, 4);
      run(0, 6'b111111, 0, len, mc, ec, il, fn);
      check("illegal_len", len, 4);
      check("illegal_pulse", il, 1);
      run_halt(0, 10, 11);
      run_halt(0, 20, 15);
      run(0, 6'b101011, 0, len, mc, ec, il, fn);
      check("sw_ready_len", len, 5);
      run(0, 6'b000111, 0, len, mc, ec, il, fn);
      run(0, 6'b010001, 0, len, mc, ec, il, fn);
      check("brfl_len", len, 4);
      run(0, 6'b011000, 0, len, mc, ec, il, fn);
      run(0, 6'b000011, 0, len, mc, ec, il, fn);
      run(0, 6'b001110, 0, len, mc, ec, il, fn);
      check("subi_fnction", fn, 6'b100010);
      run(0, 6'b001101, 0, len, mc, ec, il, fn);
      run(0, 6'b001001, 0, len, mc, ec, il, fn);
      run(0, 6'b000001, 0, len, mc, ec, il, fn);

      // Full-path build with a 5-cycle MEM timeout.
      run(1, 6'b000000, 0, len, mc, ec, il, fn);
      check("rtype_full_len", len, 5);
      run(1, 6'b001100, 0, len, mc, ec, il, fn);
      check("andi_full_len", len, 5);
      check("andi_fnction", fn, 6'b100100);
      run(1, 6'b101011, NEVER, len, mc, ec, il, fn);
      check("sw_timeout_len", len, 9);
      check("sw_timeout_mem_cycles", mc, 5);
      check("sw_timeout_err_cycle", ec, 5);
      run(1, 6'b101011, 4, len, mc, ec, il, fn);
      check("sw_late_ready_len", len, 9);
      check("sw_late_ready_no_err", ec, 0);
      run(1, 6'b100011, 0, len, mc, ec, il, fn);
      check("lw_full_len", len, 5);
      run(1, 6'b111111, 0, len, mc, ec, il, fn);
      check("illegal_full_len", len, 5);
      check("illegal_full_pulse", il, 1);

      // Asynchronous reset in the middle of a stalled lw.
      wait_fetch(0);
      iv[0] = 1'b1; op[0] = 6'b100011; mr[0] = 1'b0;
      mc = 0;
      for (int g = 0; g < 50 && mc < 2; g++) begin
         @(negedge clk);
         if (obs_a.stage == 3'd1) iv[0] = 1'b0;
         if (obs_a.stage == 3'd3) mc++;
      end
      iv[0] = 1'b0;
      check("rst_reached_mem", mc, 2);
      #2 rst_n = 1'b0;
      #1;
      o = obs_a;
      check("async_reset_all_zero", o, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_stage", obs_a.stage, 3'b000);
      check("release_cnt", obs_a.cnt, 0);
      @(negedge clk);
      check("first_fetch_req", obs_a.fetch_req, 1);
      check("first_fetch_cnt", obs_a.cnt, 0);
      run(0, 6'b001000, 0, len, mc, ec, il, fn);
      check("addi_after_reset_len", len, 4);

      @(negedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_seq.md
# multicycle_ctrl_seq

Parametrised multicycle control sequencer for the MUSA core. It replaces the free-running stage counter with an explicit stage FSM (IF, ID, EX, MEM, WB, HALT) and a fetch handshake. Memory access supports wait states with an optional timeout, and non-memory instructions can take a configurable fast path that skips MEM. It sits between instruction fetch and the datapath; it decodes the 6-bit opcode and holds stable datapath controls for the whole instruction.

## Interface
- FAST_PATH, 1, 1: instructions other than lw/sw skip MEM; 0: every instruction passes through all five stages.
- MEM_WAIT_MAX, 0, maximum cycles spent in MEM waiting for mem_ready; 0 means wait forever.
- CNT_W, 4, width of stage_cnt and of the timeout counter; requires MEM_WAIT_MAX < 2^CNT_W.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  fetch has the instruction word ready; sampled only in IF.
- opcode  in  6  opcode of the fetched instruction; captured on the IF->ID transition.
- mem_ready  in  1  data memory done; sampled only in MEM.
- resume  in  1  leave HALT; sampled only in HALT.
- stage  out  3  IF=000, ID=001, EX=010, MEM=011, WB=100, HALT=101.
- fetch_req  out  1  high while in IF.
- mem_req  out  1  high while in MEM.
- read_reg, write_reg, read_data, write_data, immediat, control_function, control_alu_data, rtrn, pop, push, add_pc, brfl_control  out  1 each  decoded control levels.
- branch  out  3  branch mode.
- fnction  out  6  ALU function override for I-type instructions.
- write_pc  out  1  one-cycle pulse in the final stage of every non-halt instruction.
- illegal  out  1  one-cycle pulse in ID when the opcode is undefined.
- mem_err  out  1  one-cycle pulse when the MEM timeout expires.
- stage_cnt  out  CNT_W  cycles elapsed in the current instruction; saturates at all-ones.

## Operation
- Reset: stage=IF, all outputs 0, stage_cnt=0.
- IF: fetch_req=1. When instr_valid=1, capture opcode, load the decoded controls into output registers and go to ID. Otherwise stay in IF.
- Decode table (opcode: nonzero outputs). Every unlisted control is 0.
  - 000000 r_type: read_reg, write_reg.
  - 001000 / 001110 / 001100 / 001101 (addi/subi/andi/ori): read_reg, write_reg, immediat, control_function; fnction = 100000 / 100010 / 100100 / 100101.
  - 100011 lw: read_reg, write_reg, write_data, immediat, control_function, control_alu_data; fnction=100000.
  - 101011 sw: same as lw except write_reg=0.
  - 000011 call: read_reg, push.
  - 000111 ret: read_reg, pop, add_pc.
  - 011000 jr: read_reg, immediat, branch=010.
  - 001001 jpc: immediat, branch=010.
  - 010001 brfl: read_reg, branch=100, brfl_control.
  - 000010 halt: branch=101.
  - 000001 nop: no controls.
  - Any other opcode: treated as nop and illegal pulses.
- ID -> EX always. If the opcode is halt, ID -> HALT instead.
- EX -> MEM for lw/sw, or for any instruction when FAST_PATH=0. Otherwise EX -> WB.
- MEM: mem_req=1. Go to WB when mem_ready=1, or when the timeout expires.
  - Timeout: MEM_WAIT_MAX>0 and MEM_WAIT_MAX cycles have been spent in MEM without mem_ready. mem_err pulses in that last MEM cycle.
  - mem_ready and timeout in the same cycle: mem_ready wins and there is no mem_err.
  - A non-memory instruction in MEM (FAST_PATH=0) ignores mem_ready and spends exactly 1 cycle there.
- WB: write_pc=1 for one cycle, then IF. All controls clear to 0 on the WB->IF transition.
- HALT: controls clear to 0; write_pc stays 0. Stay until resume=1, then go to IF.
- stage_cnt: 0 in the cycle the FSM enters IF, incremented every cycle after that, saturates.

## Timing
- Controls are registered outputs, stable from the first ID cycle through the last WB cycle. No combinational path from opcode to outputs.
- With instr_valid held high, instruction lengths (IF..WB inclusive):
  - ALU or branch instruction: 4 cycles with FAST_PATH=1, 5 cycles with FAST_PATH=0.
  - lw/sw with mem_ready high: 5 cycles.
  - Each cycle mem_ready is low adds one cycle.
- write_pc is high exactly during the WB cycle; the next instruction's IF follows immediately.
- rst_n assertion mid-instruction immediately forces IF and zeroes all outputs, including pulses. The first fetch follows the first posedge after release.

## Test plan
- Reset, then addi (001000) with instr_valid=1 and FAST_PATH=1 -> stage 000,001,010,100; fnction=100000 and immediat=1 during ID..WB; write_pc high only in cycle 4.
- lw (100011) with mem_ready low for 3 cycles, then high -> MEM held 4 cycles, mem_req=1 throughout, 8-cycle instruction, write_reg=1 and control_alu_data=1 stable.
- MEM_WAIT_MAX=5, sw with mem_ready stuck at 0 -> mem_err pulses in the 5th MEM cycle, then WB with write_pc=1; repeat with mem_ready rising in that same cycle -> no mem_err.
- halt (000010) -> stage 101 after ID, write_pc never asserts; resume asserted after 10 cycles -> IF on the next cycle, controls all 0.
- Undefined opcode 111111 -> illegal pulses in ID, all controls 0, 4-cycle completion; FAST_PATH=0 build runs the same r_type in 5 cycles.
- rst_n dropped during MEM of lw -> all outputs 0 asynchronously; after release, stage=IF and stage_cnt=0.
